// File: rtl/seg_disp_pkg.sv
// rtl/seg_disp_pkg.sv - shared constants for the seven-segment display path
//
// Purpose: digit code values, active-low segment patterns {g,f,e,d,c,b,a}
//          and blink phase encodings shared by the scan driver and decoder.
package seg_disp_pkg;

    localparam logic [3:0] CODE_DASH = 4'hA;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] seg7_0    = 7'b1000000;
    localparam logic [6:0] seg7_1    = 7'b1111001;
    localparam logic [6:0] seg7_2    = 7'b0100100;
    localparam logic [6:0] seg7_3    = 7'b0110000;
    localparam logic [6:0] seg7_4    = 7'b0011001;
    localparam logic [6:0] seg7_5    = 7'b0010010;
    localparam logic [6:0] seg7_6    = 7'b0000010;
    localparam logic [6:0] seg7_7    = 7'b1111000;
    localparam logic [6:0] seg7_8    = 7'b0000000;
    localparam logic [6:0] seg7_9    = 7'b0010000;
    localparam logic [6:0] seg7_dash = 7'b0111111;

    localparam logic PHASE_VISIBLE = 1'b0;
    localparam logic PHASE_HIDDEN  = 1'b1;

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - 4-bit digit code to active-low seven-segment pattern
//
// Purpose: combinational decoder; 0-9 give digits, 4'hA a dash, the rest blank.
// Ports:   code - 4-bit digit code
//          seg  - segments {g,f,e,d,c,b,a}, active-low
module seg7_decode
    import seg_disp_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (code)
            4'd0:      seg = seg7_0;
            4'd1:      seg = seg7_1;
            4'd2:      seg = seg7_2;
            4'd3:      seg = seg7_3;
            4'd4:      seg = seg7_4;
            4'd5:      seg = seg7_5;
            4'd6:      seg = seg7_6;
            4'd7:      seg = seg7_7;
            4'd8:      seg = seg7_8;
            4'd9:      seg = seg7_9;
            CODE_DASH: seg = seg7_dash;
            default:   seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_display.sv
// rtl/seg_scan_display.sv - 8-digit multiplexed seven-segment driver with blink
//
// Purpose: scans one digit per SCAN_DIV cycles, decodes its code, blanks the
//          anodes for BLANK_CYC cycles at each slot start and hides digits
//          selected by which_shine during the hidden half of the blink period.
// Ports:   clk, reset (async, active-high)
//          led1Number..led8Number - digit codes, led1Number is rightmost
//          point       - per-digit decimal point, active-low
//          which_shine - per-digit blink select
//          is_shine    - global blink enable
//          an          - digit enables, active-low (bit i = digit i+1)
//          seg         - segments {g,f,e,d,c,b,a}, active-low
//          dp          - decimal point, active-low
module seg_scan_display
    import seg_disp_pkg::*;
#(
    parameter int SCAN_DIV  = 100_000,
    parameter int BLINK_DIV = 50_000_000,
    parameter int BLANK_CYC = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] led1Number,
    input  logic [3:0] led2Number,
    input  logic [3:0] led3Number,
    input  logic [3:0] led4Number,
    input  logic [3:0] led5Number,
    input  logic [3:0] led6Number,
    input  logic [3:0] led7Number,
    input  logic [3:0] led8Number,
    input  logic [7:0] point,
    input  logic [7:0] which_shine,
    input  logic       is_shine,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [SCAN_W-1:0]  BLANK_END  = SCAN_W'(BLANK_CYC);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [2:0]         digit_idx;
    logic [SCAN_W-1:0]  scan_cnt;
    logic [BLINK_W-1:0] blink_cnt;
    logic               phase;

    logic [3:0] cur_code;
    logic [6:0] cur_seg;
    logic       blank_slot;
    logic       blink_off;

    always_comb begin
        cur_code = led1Number;
        case (digit_idx)
            3'd0: cur_code = led1Number;
            3'd1: cur_code = led2Number;
            3'd2: cur_code = led3Number;
            3'd3: cur_code = led4Number;
            3'd4: cur_code = led5Number;
            3'd5: cur_code = led6Number;
            3'd6: cur_code = led7Number;
            3'd7: cur_code = led8Number;
            default: cur_code = led1Number;
        endcase
    end

    seg7_decode u_decode (
        .code (cur_code),
        .seg  (cur_seg)
    );

    // Anodes stay dark briefly after each digit switch so the previous
    // digit's segment drive cannot ghost onto the new one.
    assign blank_slot = (scan_cnt < BLANK_END);
    assign blink_off  = is_shine & which_shine[digit_idx] & (phase == PHASE_HIDDEN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt  <= '0;
            digit_idx <= 3'd0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt  <= '0;
            digit_idx <= digit_idx + 3'd1;
        end else begin
            scan_cnt  <= scan_cnt + SCAN_W'(1);
        end
    end

    // Holding the counter at zero while blinking is off makes every entry
    // into set mode begin with a full visible half-period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt <= '0;
            phase     <= PHASE_VISIBLE;
        end else if (!is_shine) begin
            blink_cnt <= '0;
            phase     <= PHASE_VISIBLE;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an  <= 8'hFF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= (blank_slot || blink_off) ? 8'hFF : ~(8'd1 << digit_idx);
            seg <= cur_seg;
            dp  <= point[digit_idx];
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// tb/tb_seg_scan_display.sv - self-checking bench for seg_scan_display
module tb_seg_scan_display;

    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 16;
    localparam int BLANK_CYC = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] led1Number = 4'd1, led2Number = 4'd2, led3Number = 4'd3, led4Number = 4'd4;
    logic [3:0] led5Number = 4'd5, led6Number = 4'd6, led7Number = 4'd7, led8Number = 4'd8;
    logic [7:0] point = 8'hFF;
    logic [7:0] which_shine = 8'h00;
    logic       is_shine = 1'b0;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t exp_q[$];

    seg_scan_display #(
        .SCAN_DIV  (SCAN_DIV),
        .BLINK_DIV (BLINK_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .led1Number  (led1Number),
        .led2Number  (led2Number),
        .led3Number  (led3Number),
        .led4Number  (led4Number),
        .led5Number  (led5Number),
        .led6Number  (led6Number),
        .led7Number  (led7Number),
        .led8Number  (led8Number),
        .point       (point),
        .which_shine (which_shine),
        .is_shine    (is_shine),
        .an          (an),
        .seg         (seg),
        .dp          (dp)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_decode(input logic [3:0] c);
        case (c)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0111111;
            default: return 7'b1111111;
        endcase
    endfunction

    // Reference model: independent counters; expected outputs are queued at
    // each rising edge and compared at the following falling edge.
    int   m_digit = 0;
    int   m_scan  = 0;
    int   m_blink = 0;
    logic m_hidden = 1'b0;

    always @(posedge clk) begin
        exp_t e;
        logic [3:0] codes [8];
        if (reset) begin
            e = '{an: 8'hFF, seg: 7'h7F, dp: 1'b1};
            m_digit = 0; m_scan = 0; m_blink = 0; m_hidden = 1'b0;
        end else begin
            codes[0] = led1Number; codes[1] = led2Number; codes[2] = led3Number; codes[3] = led4Number;
            codes[4] = led5Number; codes[5] = led6Number; codes[6] = led7Number; codes[7] = led8Number;
            e.seg = ref_decode(codes[m_digit]);
            e.dp  = point[m_digit];
            if (m_scan < BLANK_CYC || (is_shine && which_shine[m_digit] && m_hidden))
                e.an = 8'hFF;
            else
                e.an = ~(8'd1 << m_digit);
            if (m_scan == SCAN_DIV - 1) begin
                m_scan = 0;
                m_digit = (m_digit + 1) % 8;
            end else begin
                m_scan++;
            end
            if (!is_shine) begin
                m_blink = 0; m_hidden = 1'b0;
            end else if (m_blink == BLINK_DIV - 1) begin
                m_blink = 0; m_hidden = ~m_hidden;
            end else begin
                m_blink++;
            end
        end
        exp_q.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            assert ({an, seg, dp} === e) else begin
                miscompares++;
                $error("FAIL scoreboard t=%0t an/seg/dp=%h/%b/%b expected %h/%b/%b",
                       $time, an, seg, dp, e.an, e.seg, e.dp);
            end
        end
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_an(input logic [7:0] val, input int budget, output logic found);
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            step();
            if (an === val) found = 1'b1;
        end
    endtask

    initial begin
        logic found;
        int   cnt;

        repeat (3) step();
        check("reset_an", an, 8'hFF);
        check("reset_seg", {1'b0, seg}, 8'h7F);
        check("reset_dp", {7'd0, dp}, 8'h01);

        reset = 1'b0;
        step();
        check("first_slot_blank", an, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            step();
            check("digit1_an", an, 8'hFE);
            check("digit1_seg", {1'b0, seg}, {1'b0, 7'b1111001});
        end
        step();
        check("slot2_blank", an, 8'hFF);
        step();
        check("digit2_an", an, 8'hFD);
        check("digit2_seg", {1'b0, seg}, {1'b0, 7'b0100100});

        wait_an(8'h7F, 40, found);
        check("digit8_seen", {7'd0, found}, 8'h01);
        wait_an(8'hFE, 40, found);
        check("wrap_to_digit1", {7'd0, found}, 8'h01);
        repeat (32) step();
        check("refresh_period", an, 8'hFE);

        led3Number = 4'hA;
        led6Number = 4'hC;
        point = 8'b11111011;
        wait_an(8'hFB, 40, found);
        check("digit3_found", {7'd0, found}, 8'h01);
        check("dash_seg", {1'b0, seg}, {1'b0, 7'b0111111});
        check("dp3_on", {7'd0, dp}, 8'h00);
        wait_an(8'hDF, 40, found);
        check("digit6_found", {7'd0, found}, 8'h01);
        check("blank_code_seg", {1'b0, seg}, 8'h7F);
        check("dp6_off", {7'd0, dp}, 8'h01);
        led3Number = 4'd3;
        led6Number = 4'd6;
        point = 8'hFF;

        // Blink: digit 1 hidden for observations 17..32 after raising is_shine.
        which_shine = 8'h01;
        is_shine = 1'b1;
        cnt = 0;
        for (int k = 1; k <= 32; k++) begin
            step();
            if (k >= 17 && an === 8'hFE) cnt++;
        end
        check("hidden_digit1_cycles", 8'(cnt), 8'd0);
        repeat (18) step();
        is_shine = 1'b0;
        wait_an(8'hFE, 40, found);
        check("visible_after_drop", {7'd0, found}, 8'h01);
        is_shine = 1'b1;
        repeat (40) step();
        is_shine = 1'b0;
        which_shine = 8'h00;

        wait_an(8'hEF, 40, found);
        check("digit5_found", {7'd0, found}, 8'h01);
        reset = 1'b1;
        #1;
        check("async_reset_an", an, 8'hFF);
        check("async_reset_seg", {1'b0, seg}, 8'h7F);
        check("async_reset_dp", {7'd0, dp}, 8'h01);
        step();
        reset = 1'b0;
        step();
        check("restart_blank", an, 8'hFF);
        step();
        check("restart_digit1", an, 8'hFE);
        repeat (10) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
